// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multicycle signed 32-bit divider for the multicycle MIPS datapath. It answers
// the control unit's DivOp start/end handshake. Magnitudes are divided with a
// 32-step restoring algorithm, then the sign is applied to the quotient (LO)
// and to the remainder (HI). The remainder takes the sign of the dividend.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-low reset
//   dividend   in   32  signed dividend (A register)
//   divisor    in   32  signed divisor (B register)
//   div_start  in   1   start request; only looked at in IDLE
//   lo_out     out  32  quotient, held until the next result
//   hi_out     out  32  remainder, held until the next result
//   div_end    out  1   one-cycle completion pulse
//   div_zero   out  1   one-cycle divide-by-zero flag, coincident with div_end
//
// Build option
//   DIV_ZERO_TRAP_EN : when defined, a zero divisor at start skips the division.
//                      The unit then pulses div_end and div_zero on the
//                      following cycle and leaves lo_out/hi_out unchanged.
//                      When undefined, div_zero is tied low. A zero divisor
//                      then runs the normal path and gives quo=0xFFFFFFFF and
//                      rem=|dividend| before the sign is applied.
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        div_start,
    output logic [31:0] lo_out,
    output logic [31:0] hi_out,
    output logic        div_end,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic [32:0] rem_reg;          // partial remainder
    logic [31:0] quo_reg;          // dividend magnitude shifting out, quotient shifting in
    logic [31:0] divisor_abs_reg;
    logic [5:0]  step_cnt_reg;
    logic        sign_q_reg;
    logic        sign_r_reg;

    // Magnitudes. The two's complement of 0x80000000 is 0x80000000, and that
    // result is correct when read as an unsigned value.
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    assign dividend_abs = dividend[31] ? (~dividend + 32'd1) : dividend;
    assign divisor_abs  = divisor[31]  ? (~divisor  + 32'd1) : divisor;

    // One restoring step: shift {rem, quo} left and do a trial subtract.
    // The remainder is always below divisor_abs (at most 2^31), so the
    // shifted value fits in 33 bits. Bit 32 of the trial difference set
    // means the difference is negative, and the shifted value is kept.
    logic [32:0] shifted_rem;
    logic [32:0] trial;
    logic        trial_ok;
    assign shifted_rem = (rem_reg << 1) | {32'd0, quo_reg[31]};
    assign trial       = shifted_rem - {1'b0, divisor_abs_reg};
    assign trial_ok    = ~trial[32];

`ifdef DIV_ZERO_TRAP_EN
    logic div_zero_reg;
    assign div_zero = div_zero_reg;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            rem_reg         <= '0;
            quo_reg         <= '0;
            divisor_abs_reg <= '0;
            step_cnt_reg    <= '0;
            sign_q_reg      <= 1'b0;
            sign_r_reg      <= 1'b0;
            lo_out          <= '0;
            hi_out          <= '0;
            div_end         <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_reg    <= 1'b0;
`endif
        end else begin
            // The completion flags are pulses. They are raised only on the
            // cycle that moves the FSM into DONE.
            div_end <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (div_start) begin
`ifdef DIV_ZERO_TRAP_EN
                        if (divisor == 32'd0) begin
                            state_reg    <= DONE;
                            div_end      <= 1'b1;
                            div_zero_reg <= 1'b1;
                        end else
`endif
                        begin
                            quo_reg         <= dividend_abs;
                            divisor_abs_reg <= divisor_abs;
                            sign_q_reg      <= dividend[31] ^ divisor[31];
                            sign_r_reg      <= dividend[31];
                            rem_reg         <= '0;
                            step_cnt_reg    <= '0;
                            state_reg       <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (trial_ok) begin
                        rem_reg <= trial;
                        quo_reg <= {quo_reg[30:0], 1'b1};
                    end else begin
                        rem_reg <= shifted_rem;
                        quo_reg <= {quo_reg[30:0], 1'b0};
                    end
                    step_cnt_reg <= step_cnt_reg + 6'd1;
                    if (step_cnt_reg == 6'd31) begin
                        state_reg <= SIGN;
                    end
                end

                SIGN: begin
                    // Truncating division: the quotient sign is the XOR of the
                    // operand signs, and the remainder follows the dividend.
                    lo_out    <= sign_q_reg ? (~quo_reg + 32'd1) : quo_reg;
                    hi_out    <= sign_r_reg ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];
                    div_end   <= 1'b1;
                    state_reg <= DONE;
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
